alu_in: RTL and testbench



---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_in_comb.sv | 77 +++++++
 rtl/alu_in.sv | 59 +++++
 tb/tb_alu_in.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the alu_in datapath block:
// default operand width and the 4-bit opcode map.
package alu_pkg;

  localparam int WIDTH = 16;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_ROL   = 4'd9;
  localparam logic [3:0] OP_ROR   = 4'd10;
  localparam logic [3:0] OP_SLT   = 4'd11;
  localparam logic [3:0] OP_SLTU  = 4'd12;
  localparam logic [3:0] OP_PASSB = 4'd13;
  localparam logic [3:0] OP_ACC   = 4'd14;
  localparam logic [3:0] OP_CLR   = 4'd15;

endpackage

// File: rtl/alu_in_comb.sv
// Combinational core of alu_in: next sum and next carry from aa/bb/op/runsum.
// Ports: aa_i, bb_i, op_i, runsum_i in; sum_d_o, c_d_o out.
module alu_in_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] aa_i,
  input  logic [WIDTH-1:0] bb_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] runsum_i,
  output logic [WIDTH-1:0] sum_d_o,
  output logic             c_d_o
);

  logic [3:0]       amt;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;
  logic [WIDTH:0]   sra_w;
  logic [WIDTH-1:0] rol_w;
  logic [WIDTH-1:0] ror_w;
  logic [WIDTH+1:0] acc_w;
  logic             slt;
  logic             sltu;

  assign amt   = bb_i[3:0];
  assign add_w = {1'b0, aa_i} + {1'b0, bb_i};
  // Top bit of the widened difference is the unsigned borrow.
  assign sub_w = {1'b0, aa_i} - {1'b0, bb_i};
  // Shifts carry one guard bit; it holds the last bit shifted out,
  // and stays 0 for a zero amount.
  assign shl_w = {1'b0, aa_i} << amt;
  assign shr_w = {aa_i, 1'b0} >> amt;
  assign sra_w = $signed({aa_i, 1'b0}) >>> amt;
  assign rol_w = (aa_i << amt) | (aa_i >> (WIDTH - int'(amt)));
  assign ror_w = (aa_i >> amt) | (aa_i << (WIDTH - int'(amt)));
  // Two extra bits so the three-term total never wraps.
  assign acc_w = {2'b00, runsum_i} + {2'b00, aa_i} + {2'b00, bb_i};
  assign slt   = $signed(aa_i) < $signed(bb_i);
  assign sltu  = aa_i < bb_i;

  always_comb begin
    sum_d_o = '0;
    c_d_o   = 1'b0;
    unique case (op_i)
      OP_ADD:   {c_d_o, sum_d_o} = add_w;
      OP_SUB:   {c_d_o, sum_d_o} = sub_w;
      OP_AND:   sum_d_o = aa_i & bb_i;
      OP_OR:    sum_d_o = aa_i | bb_i;
      OP_XOR:   sum_d_o = aa_i ^ bb_i;
      OP_NOT:   sum_d_o = ~aa_i;
      OP_SHL:   {c_d_o, sum_d_o} = shl_w;
      OP_SHR:   {sum_d_o, c_d_o} = shr_w;
      OP_SRA:   {sum_d_o, c_d_o} = sra_w;
      OP_ROL:   sum_d_o = rol_w;
      OP_ROR:   sum_d_o = ror_w;
      OP_SLT:   sum_d_o = {{(WIDTH-1){1'b0}}, slt};
      OP_SLTU:  sum_d_o = {{(WIDTH-1){1'b0}}, sltu};
      OP_PASSB: sum_d_o = bb_i;
      OP_ACC: begin
        sum_d_o = acc_w[WIDTH-1:0];
        c_d_o   = |acc_w[WIDTH+1:WIDTH];
      end
      OP_CLR: begin
        sum_d_o = '0;
        c_d_o   = 1'b0;
      end
      default: begin
        sum_d_o = '0;
        c_d_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_in.sv
// Registered 16-entry ALU with running-sum accumulator, 1-cycle latency.
// Ports: clk, rst (async high), aa, bb, op in; sum, c_out, zero out.
module alu_in
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] aa,
  input  logic [WIDTH-1:0] bb,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             zero
);

  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] runsum_q, runsum_d;
  logic             c_q, c_d;
  logic             zero_q, zero_d;

  alu_in_comb #(.WIDTH(WIDTH)) u_comb (
    .aa_i     (aa),
    .bb_i     (bb),
    .op_i     (op),
    .runsum_i (runsum_q),
    .sum_d_o  (sum_d),
    .c_d_o    (c_d)
  );

  // Flag tracks the value being loaded, so it lines up with sum.
  assign zero_d = (sum_d == '0);

  always_comb begin
    runsum_d = runsum_q;
    if (op == OP_ACC) runsum_d = sum_d;
    else if (op == OP_CLR) runsum_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q    <= '0;
      c_q      <= 1'b0;
      zero_q   <= 1'b1;
      runsum_q <= '0;
    end else begin
      sum_q    <= sum_d;
      c_q      <= c_d;
      zero_q   <= zero_d;
      runsum_q <= runsum_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_alu_in.sv
// Bench for alu_in: directed steps from the test plan, then random ops,
// each compared against an arithmetic reference model.
module tb_alu_in;

  logic        clk;
  logic        rst;
  logic [15:0] aa;
  logic [15:0] bb;
  logic [3:0]  op;
  logic [15:0] sum;
  logic        c_out;
  logic        zero;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  longint ref_run = 0;

  alu_in dut (
    .clk   (clk),
    .rst   (rst),
    .aa    (aa),
    .bb    (bb),
    .op    (op),
    .sum   (sum),
    .c_out (c_out),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model in plain integer arithmetic.
  task automatic model(input int o, input longint a, input longint b,
                       output longint s, output longint c);
    longint n, t, sa;
    n = b % 16;
    sa = (a >= 32768) ? a - 65536 : a;
    c = 0;
    s = 0;
    case (o)
      0: begin t = a + b; s = t % 65536; c = (t >= 65536); end
      1: begin s = (a - b + 65536) % 65536; c = (a < b); end
      2: s = a & b;
      3: s = a | b;
      4: s = a ^ b;
      5: s = 65535 - a;
      6: begin
        t = a * (64'd1 << n);
        s = t % 65536;
        c = (n != 0) ? (t / 65536) % 2 : 0;
      end
      7: begin
        s = a / (64'd1 << n);
        c = (n != 0) ? (a / (64'd1 << (n - 1))) % 2 : 0;
      end
      8: begin
        s = (sa >>> n) & 65535;
        c = (n != 0) ? ((sa >>> (n - 1)) & 1) : 0;
      end
      9:  s = ((a * (64'd1 << n)) + (a / (64'd1 << (16 - n)))) % 65536;
      10: s = ((a / (64'd1 << n)) + (a * (64'd1 << (16 - n)))) % 65536;
      11: begin
        longint sb;
        sb = (b >= 32768) ? b - 65536 : b;
        s = (sa < sb) ? 1 : 0;
      end
      12: s = (a < b) ? 1 : 0;
      13: s = b;
      14: begin
        t = ref_run + a + b;
        s = t % 65536;
        c = (t >= 65536);
        ref_run = s;
      end
      default: begin s = 0; ref_run = 0; end
    endcase
  endtask

  task automatic step(input int o, input int a, input int b);
    longint es, ec;
    aa = 16'(a);
    bb = 16'(b);
    op = 4'(o);
    model(o, longint'(a), longint'(b), es, ec);
    @(posedge clk);
    #1;
    chk($sformatf("op%0d sum", o), sum, 16'(es));
    chk($sformatf("op%0d c_out", o), {15'd0, c_out}, 16'(ec));
    chk($sformatf("op%0d zero", o), {15'd0, zero},
        (es == 0) ? 16'd1 : 16'd0);
  endtask

  int acc_exp[10] = '{2, 5, 9, 14, 20, 27, 35, 44, 54, 65};

  initial begin
    aa = 0; bb = 0; op = 0;
    rst = 1'b1;
    #12;
    chk("reset sum", sum, 16'h0000);
    chk("reset c_out", {15'd0, c_out}, 16'd0);
    chk("reset zero", {15'd0, zero}, 16'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    step(0, 16'hFFFF, 1);
    chk("add wrap", sum, 16'h0000);
    chk("add carry", {15'd0, c_out}, 16'd1);
    step(1, 2, 5);
    chk("sub", sum, 16'hFFFD);

    for (int i = 0; i < 10; i++) begin
      step(14, i, 2);
      chk($sformatf("acc[%0d]", i), sum, 16'(acc_exp[i]));
    end
    step(15, 16'h1234, 16'h5678);
    chk("clr", sum, 16'h0000);
    step(14, 0, 2);
    chk("acc after clr", sum, 16'd2);

    step(6, 16'h8001, 1);
    chk("shl", sum, 16'h0002);
    step(7, 16'h8001, 1);
    chk("shr", sum, 16'h4000);
    step(8, 16'h8001, 1);
    chk("sra", sum, 16'hC000);
    chk("sra c", {15'd0, c_out}, 16'd1);
    step(6, 16'h8001, 0);
    step(7, 16'h8001, 16'hFFF0);
    step(8, 16'h8001, 0);
    chk("sra by 0", sum, 16'h8001);

    step(9, 16'h8001, 4);
    chk("rol", sum, 16'h0018);
    step(10, 16'h8001, 4);
    chk("ror", sum, 16'h1800);
    step(11, 16'hFFFF, 1);
    chk("slt", sum, 16'd1);
    step(12, 16'hFFFF, 1);
    chk("sltu", sum, 16'd0);

    step(2, 16'hF0F0, 16'h0FF0);
    chk("and", sum, 16'h00F0);
    step(3, 16'hF0F0, 16'h0FF0);
    chk("or", sum, 16'hFFF0);
    step(4, 16'hF0F0, 16'h0FF0);
    chk("xor", sum, 16'hFF00);
    step(5, 16'hF0F0, 16'h0FF0);
    chk("not", sum, 16'h0F0F);
    step(13, 16'hF0F0, 16'h0FF0);
    chk("passb", sum, 16'h0FF0);

    // Async reset mid-cycle after accumulating.
    step(14, 16'h7000, 16'h0100);
    step(14, 16'h0001, 16'h0001);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst sum", sum, 16'h0000);
    chk("async rst c", {15'd0, c_out}, 16'd0);
    chk("async rst zero", {15'd0, zero}, 16'd1);
    ref_run = 0;
    @(negedge clk);
    rst = 1'b0;
    step(14, 1, 2);
    chk("acc after rst", sum, 16'd3);

    for (int i = 0; i < 300; i++) begin
      step(int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)),
           int'($urandom_range(0, 65535)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
